// File: rtl/timer.sv
// Elapsed-seconds timer: a prescaler divides Clk down to a one-second tick
// that advances a two-digit BCD seconds count, wrapping 99 -> 00.
module timer #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Enable,
  output logic [3:0] T_Sec0,
  output logic [3:0] T_Sec1
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] prescaler;
  logic          tick;

  assign tick = Enable && (prescaler == LAST);

  // Prescaler only advances while enabled, so a pause keeps the partial second.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      prescaler <= '0;
    end else if (Enable) begin
      if (tick) prescaler <= '0;
      else      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      T_Sec0 <= 4'd0;
      T_Sec1 <= 4'd0;
    end else if (tick) begin
      if (T_Sec0 == 4'd9) begin
        T_Sec0 <= 4'd0;
        if (T_Sec1 == 4'd9) T_Sec1 <= 4'd0;
        else                T_Sec1 <= T_Sec1 + 4'd1;
      end else begin
        T_Sec0 <= T_Sec0 + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_timer.sv
// Bench for timer: a cycle-accurate seconds model feeds a scoreboard queue,
// while a table of segments checks the digit values at key points.
module tb_timer;

  localparam int TICKS     = 10;
  localparam int TICKS_BIG = 50_000_000;

  typedef struct {
    logic       rst;
    logic       en;
    int         n;
    logic [3:0] s1;
    logic [3:0] s0;
  } vec_t;

  typedef struct {
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] b1;
    logic [3:0] b0;
  } exp_t;

  logic       Clk;
  logic       Rst;
  logic       Enable;
  logic [3:0] T_Sec0, T_Sec1;
  logic [3:0] big_sec0, big_sec1;

  int   vectors;
  int   miscompares;
  int   cycle;
  int   m_cnt;
  int   m_big;
  exp_t sb[$];
  vec_t vecs[$];

  timer #(.TICKS_PER_SEC(TICKS)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .T_Sec0(T_Sec0), .T_Sec1(T_Sec1)
  );

  timer dut_big (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .T_Sec0(big_sec0), .T_Sec1(big_sec1)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard cycle %0d: got empty queue want entry", cycle);
      return;
    end
    e = sb.pop_front();
    vectors++;
    if (T_Sec1 !== e.s1 || T_Sec0 !== e.s0) begin
      miscompares++;
      $display("[TB] FAIL digits cycle %0d: got %0h%0h want %0h%0h",
               cycle, T_Sec1, T_Sec0, e.s1, e.s0);
    end
    vectors++;
    if (big_sec1 !== e.b1 || big_sec0 !== e.b0) begin
      miscompares++;
      $display("[TB] FAIL big_digits cycle %0d: got %0h%0h want %0h%0h",
               cycle, big_sec1, big_sec0, e.b1, e.b0);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en);
    exp_t e;
    int   sec;
    @(negedge Clk);
    Rst    = rst;
    Enable = en;
    if (!rst) begin
      m_cnt = 0;
      m_big = 0;
    end else if (en) begin
      m_cnt++;
      m_big++;
    end
    sec  = (m_cnt / TICKS) % 100;
    e.s0 = 4'(sec % 10);
    e.s1 = 4'(sec / 10);
    sec  = (m_big / TICKS_BIG) % 100;
    e.b0 = 4'(sec % 10);
    e.b1 = 4'(sec / 10);
    sb.push_back(e);
    @(posedge Clk);
    #1;
    cycle++;
    checkOutput();
  endtask

  task automatic runSegment(input vec_t v);
    for (int i = 0; i < v.n; i++) applyStimulus(v.rst, v.en);
    vectors++;
    if (T_Sec1 !== v.s1 || T_Sec0 !== v.s0) begin
      miscompares++;
      $display("[TB] FAIL segment cycle %0d: got %0h%0h want %0h%0h",
               cycle, T_Sec1, T_Sec0, v.s1, v.s0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    m_cnt       = 0;
    m_big       = 0;
    Rst         = 1'b0;
    Enable      = 1'b1;

    // Reset, first tick, 09->10 carry, 99 and the 99->00 wrap.
    vecs.push_back('{1'b0, 1'b1, 2,   4'd0, 4'd0});
    vecs.push_back('{1'b1, 1'b1, 9,   4'd0, 4'd0});
    vecs.push_back('{1'b1, 1'b1, 1,   4'd0, 4'd1});
    vecs.push_back('{1'b1, 1'b1, 89,  4'd0, 4'd9});
    vecs.push_back('{1'b1, 1'b1, 1,   4'd1, 4'd0});
    vecs.push_back('{1'b1, 1'b1, 889, 4'd9, 4'd8});
    vecs.push_back('{1'b1, 1'b1, 1,   4'd9, 4'd9});
    vecs.push_back('{1'b1, 1'b1, 9,   4'd9, 4'd9});
    vecs.push_back('{1'b1, 1'b1, 1,   4'd0, 4'd0});
    // Reset with Enable low, then pause mid-second and resume.
    vecs.push_back('{1'b0, 1'b0, 1,   4'd0, 4'd0});
    vecs.push_back('{1'b1, 1'b1, 5,   4'd0, 4'd0});
    vecs.push_back('{1'b1, 1'b0, 50,  4'd0, 4'd0});
    vecs.push_back('{1'b1, 1'b1, 4,   4'd0, 4'd0});
    vecs.push_back('{1'b1, 1'b1, 1,   4'd0, 4'd1});
    // Reach 37, go mid-second, reset discards the partial count.
    vecs.push_back('{1'b1, 1'b1, 360, 4'd3, 4'd7});
    vecs.push_back('{1'b1, 1'b1, 5,   4'd3, 4'd7});
    vecs.push_back('{1'b0, 1'b1, 1,   4'd0, 4'd0});
    vecs.push_back('{1'b1, 1'b1, 9,   4'd0, 4'd0});
    vecs.push_back('{1'b1, 1'b1, 1,   4'd0, 4'd1});

    for (int k = 0; k < vecs.size(); k++) runSegment(vecs[k]);

    // Reset on the very edge a tick would fire must win.
    runSegment('{1'b1, 1'b1, 9, 4'd0, 4'd1});
    runSegment('{1'b0, 1'b1, 1, 4'd0, 4'd0});
    runSegment('{1'b1, 1'b1, 9, 4'd0, 4'd0});
    runSegment('{1'b1, 1'b1, 1, 4'd0, 4'd1});

    // Pause exactly on the tick boundary, then resume.
    runSegment('{1'b1, 1'b1, 9,  4'd0, 4'd1});
    runSegment('{1'b1, 1'b0, 20, 4'd0, 4'd1});
    runSegment('{1'b1, 1'b1, 1,  4'd0, 4'd2});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 50_000_000, gives the number of Clk cycles per one-second tick (50 MHz clock); it SHALL be legal for any value >= 2.
REQ-002 Port Clk, input, 1, SHALL be the single clock; all state SHALL update on the rising edge.
REQ-003 Port Rst, input, 1, SHALL be a synchronous, active-low reset.
REQ-004 Port Enable, input, 1, SHALL be the count enable: 1 = run, 0 = pause.
REQ-005 Port T_Sec0, output, 4, SHALL be the BCD units digit of elapsed seconds (0-9).
REQ-006 Port T_Sec1, output, 4, SHALL be the BCD tens digit of elapsed seconds (0-9).

Function
REQ-007 The block SHALL contain a prescaler counter of width ceil(log2(TICKS_PER_SEC)) bits, counting 0 .. TICKS_PER_SEC-1.
REQ-008 With Enable=1, the prescaler SHALL increment by 1 each Clk cycle.
REQ-009 When the prescaler equals TICKS_PER_SEC-1 with Enable=1, on that edge it SHALL return to 0 and a one-second tick SHALL occur.
REQ-010 On a tick, T_Sec0 SHALL increment by 1; if T_Sec0 was 9 it SHALL become 0 and T_Sec1 SHALL increment by 1.
REQ-011 On a tick with T_Sec1=9 and T_Sec0=9, both digits SHALL wrap to 0 (count 99 -> 00), with no other indication.
REQ-012 With Enable=0, the prescaler, T_Sec0 and T_Sec1 SHALL all hold their values (pause, not clear).
REQ-013 When Enable returns to 1, counting SHALL resume from the held prescaler value, so accumulated enabled time is exact.
REQ-014 The first tick after reset SHALL occur on the TICKS_PER_SEC-th rising edge at which Enable=1 and Rst=1.
REQ-015 T_Sec0 and T_Sec1 SHALL be driven directly from registers, with no combinational path from inputs.
REQ-016 Neither digit SHALL ever hold a value above 9.

Reset
REQ-017 When Rst=0 at a rising Clk edge, the prescaler, T_Sec0 and T_Sec1 SHALL all become 0, regardless of Enable.
REQ-018 Reset SHALL take priority over ticking and counting on the same edge.
REQ-019 Reset asserted mid-second SHALL discard the partial prescaler count.
REQ-020 Until the first Clk edge with Rst=0, output values are don't-care; the bench SHALL apply reset before checking outputs.

Verification (benches use TICKS_PER_SEC=10 unless noted)
REQ-021 Rst=0 for 2 cycles, then Rst=1 with Enable=1:
- digits stay 00 for 9 edges;
- digits read 01 after the 10th edge.
REQ-022 Enable=1 for 100 cycles after reset: digits = 10 (T_Sec1=1, T_Sec0=0); check the 09 -> 10 carry at cycle 100.
REQ-023 Enable=1 for 1000 cycles: digits = 00 (wrapped from 99); at cycle 990 digits = 99.
REQ-024 Enable=1 for 5 cycles, Enable=0 for 50 cycles, Enable=1 for 5 cycles:
- digits stay 00 throughout the pause;
- digits read 01 exactly at the 10th enabled cycle.
REQ-025 After reaching 37, assert Rst=0 for one cycle while Enable=1: digits = 00 on the next edge; the next tick arrives 10 enabled cycles after Rst returns to 1.
REQ-026 Default parameter, Enable=1 for 222,222,200 ns of 20 ns Clk after reset, then Enable=0: digits = 00 throughout, since no full second elapses.
